// File: rtl/qpl_req_arbiter.sv
// ---------------------------------------------------------------------------
// qpl_req_arbiter
//
// Round-robin front-end that lets NREQ requesters share a single
// QuickPageLite allocator/deallocator core. Requests are accepted one at a
// time, tagged with the requester ID in the top bits of the core payload, and
// issued on the core's alloc or dealloc request channel. Replies from both
// core reply channels are merged through one registered reply stage and
// steered back to the originating requester with the ID stripped.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_req_vld/op/data       per-requester request (op 0 = alloc, 1 = dealloc)
//   o_req_rdy               one-hot request accept
//   o_alloc_*  / i_alloc_rdy     core alloc request channel   {id, udata, obj}
//   o_dealloc_*/ i_dealloc_rdy   core dealloc request channel {id, udata, obj}
//   i_rep_alloc_*   / o_rep_alloc_rdy    core alloc reply
//   i_rep_dealloc_* / o_rep_dealloc_rdy  core dealloc reply
//   o_rep_vld (one-hot), o_rep_op, o_rep_data, i_rep_rdy   requester reply
// ---------------------------------------------------------------------------
module qpl_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int BLOCK_D = 512,
  parameter int UDATA_W = 8,
  localparam int ID_W    = $clog2(NREQ),
  localparam int BLOCK_W = $clog2(BLOCK_D),
  localparam int OBJ_W   = 2*BLOCK_W + 1,
  localparam int REP_W   = UDATA_W + OBJ_W,
  localparam int CREP_W  = ID_W + UDATA_W + OBJ_W
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  // requester side
  input  logic [NREQ-1:0]             i_req_vld,
  input  logic [NREQ-1:0]             i_req_op,
  input  logic [NREQ-1:0][REP_W-1:0]  i_req_data,
  output logic [NREQ-1:0]             o_req_rdy,
  // core request channels
  output logic                        o_alloc_vld,
  input  logic                        i_alloc_rdy,
  output logic [CREP_W-1:0]           o_alloc_data,
  output logic                        o_dealloc_vld,
  input  logic                        i_dealloc_rdy,
  output logic [CREP_W-1:0]           o_dealloc_data,
  // core reply channels
  input  logic                        i_rep_alloc_vld,
  input  logic [CREP_W-1:0]           i_rep_alloc_data,
  output logic                        o_rep_alloc_rdy,
  input  logic                        i_rep_dealloc_vld,
  input  logic [CREP_W-1:0]           i_rep_dealloc_data,
  output logic                        o_rep_dealloc_rdy,
  // requester reply
  output logic [NREQ-1:0]             o_rep_vld,
  output logic                        o_rep_op,
  output logic [REP_W-1:0]            o_rep_data,
  input  logic [NREQ-1:0]             i_rep_rdy
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // Request path
  // -------------------------------------------------------------------------
  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   grant_id;
  logic              grant_vld;
  logic [ID_W-1:0]   hold_id;
  logic              hold_op;
  logic [REP_W-1:0]  hold_data;
  logic              alloc_vld_q;
  logic              dealloc_vld_q;

  // Scan from rr_ptr upward, wrapping modulo NREQ; the first valid wins.
  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin : grant_scan
    int idx;
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_vld && i_req_vld[ID_W'(idx)]) begin
        grant_vld = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
  end

  // Accept is offered only in IDLE, and never while reset is asserted so all
  // outputs read zero during reset.
  always_comb begin
    o_req_rdy = '0;
    if (state == IDLE && grant_vld && !i_rst) o_req_rdy[grant_id] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      hold_id       <= '0;
      hold_op       <= 1'b0;
      hold_data     <= '0;
      alloc_vld_q   <= 1'b0;
      dealloc_vld_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            hold_id       <= grant_id;
            hold_op       <= i_req_op[grant_id];
            hold_data     <= i_req_data[grant_id];
            rr_ptr        <= (grant_id == ID_W'(NREQ-1)) ? '0 : grant_id + 1'b1;
            alloc_vld_q   <= !i_req_op[grant_id];
            dealloc_vld_q <= i_req_op[grant_id];
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if ((alloc_vld_q && i_alloc_rdy) || (dealloc_vld_q && i_dealloc_rdy)) begin
            alloc_vld_q   <= 1'b0;
            dealloc_vld_q <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Both core channels see the holding register; only vld qualifies them.
  assign o_alloc_vld    = alloc_vld_q;
  assign o_dealloc_vld  = dealloc_vld_q;
  assign o_alloc_data   = {hold_id, hold_data};
  assign o_dealloc_data = {hold_id, hold_data};

  // -------------------------------------------------------------------------
  // Reply path
  // -------------------------------------------------------------------------
  logic              rep_full;
  logic [ID_W-1:0]   rep_id;
  logic              rep_op;
  logic [REP_W-1:0]  rep_data;
  logic              last_src;   // source of the last tie winner, 1 = dealloc

  logic              rep_load;
  logic              tie;
  logic              sel_dealloc;
  logic              sel_any;
  logic              rep_hs;
  logic [CREP_W-1:0] sel_data;
  logic [ID_W-1:0]   sel_id;
  logic              id_ok;

  always_comb begin
    // The stage can take a new reply when empty or when its current
    // reply is being consumed this cycle.
    rep_load          = !i_rst && (!rep_full || i_rep_rdy[rep_id]);
    tie               = i_rep_alloc_vld && i_rep_dealloc_vld;
    sel_dealloc       = tie ? !last_src : i_rep_dealloc_vld;
    sel_any           = i_rep_alloc_vld || i_rep_dealloc_vld;
    o_rep_alloc_rdy   = rep_load && sel_any && !sel_dealloc;
    o_rep_dealloc_rdy = rep_load && sel_dealloc;
    rep_hs            = o_rep_alloc_rdy || o_rep_dealloc_rdy;
    sel_data          = sel_dealloc ? i_rep_dealloc_data : i_rep_alloc_data;
    sel_id            = sel_data[CREP_W-1 -: ID_W];
    // IDs beyond NREQ (non-power-of-2 NREQ) have no requester to go to.
    id_ok             = int'(sel_id) < NREQ;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rep_full <= 1'b0;
      rep_id   <= '0;
      rep_op   <= 1'b0;
      rep_data <= '0;
      last_src <= 1'b1;
    end else begin
      if (rep_hs) begin
        rep_full <= id_ok;
        rep_id   <= sel_id;
        rep_op   <= sel_dealloc;
        rep_data <= sel_data[REP_W-1:0];
        if (tie) last_src <= sel_dealloc;
      end else if (rep_load) begin
        rep_full <= 1'b0;
      end
    end
  end

  always_comb begin
    o_rep_vld = '0;
    for (int i = 0; i < NREQ; i++) begin
      o_rep_vld[i] = rep_full && (rep_id == ID_W'(i));
    end
  end

  assign o_rep_op   = rep_op;
  assign o_rep_data = rep_data;

endmodule

// File: tb/tb_qpl_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_qpl_req_arbiter
//
// Directed bench for qpl_req_arbiter with NREQ=4, BLOCK_D=512, UDATA_W=8.
// Inputs change 1 time unit after the rising edge; outputs are compared
// 2 time units after the edge, well clear of the next edge.
// ---------------------------------------------------------------------------
module tb_qpl_req_arbiter;

  localparam int NREQ    = 4;
  localparam int BLOCK_D = 512;
  localparam int UDATA_W = 8;
  localparam int ID_W    = 2;
  localparam int REP_W   = 27;
  localparam int CREP_W  = 29;

  logic                       clk;
  logic                       rst;
  logic [NREQ-1:0]            req_vld;
  logic [NREQ-1:0]            req_op;
  logic [NREQ-1:0][REP_W-1:0] req_data;
  logic [NREQ-1:0]            req_rdy;
  logic                       alloc_vld;
  logic                       alloc_rdy;
  logic [CREP_W-1:0]          alloc_data;
  logic                       dealloc_vld;
  logic                       dealloc_rdy;
  logic [CREP_W-1:0]          dealloc_data;
  logic                       rep_alloc_vld;
  logic [CREP_W-1:0]          rep_alloc_data;
  logic                       rep_alloc_rdy;
  logic                       rep_dealloc_vld;
  logic [CREP_W-1:0]          rep_dealloc_data;
  logic                       rep_dealloc_rdy;
  logic [NREQ-1:0]            rep_vld;
  logic                       rep_op;
  logic [REP_W-1:0]           rep_data;
  logic [NREQ-1:0]            rep_rdy;

  int n_checks = 0;
  int n_fail   = 0;

  qpl_req_arbiter #(
    .NREQ    (NREQ),
    .BLOCK_D (BLOCK_D),
    .UDATA_W (UDATA_W)
  ) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_req_vld          (req_vld),
    .i_req_op           (req_op),
    .i_req_data         (req_data),
    .o_req_rdy          (req_rdy),
    .o_alloc_vld        (alloc_vld),
    .i_alloc_rdy        (alloc_rdy),
    .o_alloc_data       (alloc_data),
    .o_dealloc_vld      (dealloc_vld),
    .i_dealloc_rdy      (dealloc_rdy),
    .o_dealloc_data     (dealloc_data),
    .i_rep_alloc_vld    (rep_alloc_vld),
    .i_rep_alloc_data   (rep_alloc_data),
    .o_rep_alloc_rdy    (rep_alloc_rdy),
    .i_rep_dealloc_vld  (rep_dealloc_vld),
    .i_rep_dealloc_data (rep_dealloc_data),
    .o_rep_dealloc_rdy  (rep_dealloc_rdy),
    .o_rep_vld          (rep_vld),
    .o_rep_op           (rep_op),
    .o_rep_data         (rep_data),
    .i_rep_rdy          (rep_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requester payload {udata, size[9:0], base[8:0]}.
  function automatic logic [REP_W-1:0] pay(input logic [7:0] u, input logic [9:0] sz,
                                            input logic [8:0] b);
    return {u, sz, b};
  endfunction

  logic [REP_W-1:0] p_single, p_bp, p_a, p_d, p_r1, p_r2, p_r3, p_s;

  initial begin
    p_single = pay(8'h5A, 10'd4, 9'd0);
    p_bp     = pay(8'hB7, 10'd8, 9'd37);
    p_a      = pay(8'hA1, 10'd2, 9'd10);
    p_d      = pay(8'hD1, 10'd3, 9'd20);
    p_r1     = pay(8'h11, 10'd5, 9'd1);
    p_r2     = pay(8'h22, 10'd6, 9'd2);
    p_r3     = pay(8'h33, 10'd7, 9'd3);
    p_s      = pay(8'hCC, 10'd9, 9'd0);

    rst              = 1'b1;
    req_vld          = '0;
    req_op           = '0;
    req_data         = '0;
    alloc_rdy        = 1'b0;
    dealloc_rdy      = 1'b0;
    rep_alloc_vld    = 1'b0;
    rep_alloc_data   = '0;
    rep_dealloc_vld  = 1'b0;
    rep_dealloc_data = '0;
    rep_rdy          = '1;

    // ---- reset state ----
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_req_rdy",     32'(req_rdy),      32'h0);
    check("rst_alloc_vld",   32'(alloc_vld),    32'h0);
    check("rst_dealloc_vld", 32'(dealloc_vld),  32'h0);
    check("rst_alloc_data",  32'(alloc_data),   32'h0);
    check("rst_rep_vld",     32'(rep_vld),      32'h0);
    check("rst_rep_data",    32'(rep_data),     32'h0);

    // ---- single alloc from requester 2 ----
    tick();
    req_vld     = 4'b0100;
    req_op      = 4'b0000;
    req_data[2] = p_single;
    alloc_rdy   = 1'b1;
    #1;
    check("single_req_rdy", 32'(req_rdy), 32'h4);
    tick();
    req_vld = '0;
    #1;
    check("single_alloc_vld",   32'(alloc_vld),   32'h1);
    check("single_dealloc_vld", 32'(dealloc_vld), 32'h0);
    check("single_alloc_data",  32'(alloc_data),  32'({2'd2, p_single}));
    check("single_issue_rdy",   32'(req_rdy),     32'h0);
    tick();
    #1;
    check("single_back_idle", 32'(alloc_vld), 32'h0);
    // core answers with id 2
    rep_alloc_vld  = 1'b1;
    rep_alloc_data = {2'd2, p_single};
    #1;
    check("single_core_rep_rdy", 32'(rep_alloc_rdy), 32'h1);
    tick();
    rep_alloc_vld = 1'b0;
    #1;
    check("single_rep_vld",  32'(rep_vld),  32'h4);
    check("single_rep_op",   32'(rep_op),   32'h0);
    check("single_rep_data", 32'(rep_data), 32'(p_single));
    tick();
    #1;
    check("single_rep_drain", 32'(rep_vld), 32'h0);

    // ---- round-robin fairness from a fresh reset ----
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) req_data[i] = pay(8'(16 + i), 10'd1, 9'd0);
    req_op  = 4'b0000;
    req_vld = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("rr_grant", 32'(req_rdy), 32'(1 << (k % NREQ)));
      tick();
      #1;
      check("rr_issue_rdy", 32'(req_rdy),   32'h0);
      check("rr_issue_vld", 32'(alloc_vld), 32'h1);
      check("rr_issue_data", 32'(alloc_data),
            32'({2'(k % NREQ), pay(8'(16 + (k % NREQ)), 10'd1, 9'd0)}));
      tick();
    end

    // ---- dealloc backpressure (rr_ptr is now 1) ----
    req_vld     = 4'b1000;
    req_op      = 4'b1000;
    req_data[3] = p_bp;
    dealloc_rdy = 1'b0;
    #1;
    check("bp_grant", 32'(req_rdy), 32'h8);
    tick();
    req_vld = 4'b0111;
    req_op  = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_dealloc_vld",  32'(dealloc_vld),  32'h1);
      check("bp_alloc_vld",    32'(alloc_vld),    32'h0);
      check("bp_dealloc_data", 32'(dealloc_data), 32'({2'd3, p_bp}));
      check("bp_req_rdy",      32'(req_rdy),      32'h0);
      tick();
    end
    dealloc_rdy = 1'b1;
    #1;
    check("bp_release_vld", 32'(dealloc_vld), 32'h1);
    tick();
    #1;
    check("bp_idle_vld", 32'(dealloc_vld), 32'h0);
    check("bp_wrap_grant", 32'(req_rdy), 32'h1);
    req_vld = '0;

    // ---- reply collision: alloc wins the first tie, then alternate ----
    rep_rdy          = 4'b1111;
    rep_alloc_vld    = 1'b1;
    rep_alloc_data   = {2'd0, p_a};
    rep_dealloc_vld  = 1'b1;
    rep_dealloc_data = {2'd1, p_d};
    for (int k = 0; k < 4; k++) begin
      #1;
      check("coll_alloc_rdy",   32'(rep_alloc_rdy),   32'(k % 2 == 0));
      check("coll_dealloc_rdy", 32'(rep_dealloc_rdy), 32'(k % 2 == 1));
      tick();
      if (k == 3) begin
        rep_alloc_vld   = 1'b0;
        rep_dealloc_vld = 1'b0;
      end
      #1;
      check("coll_rep_vld",  32'(rep_vld),  (k % 2 == 0) ? 32'h1 : 32'h2);
      check("coll_rep_op",   32'(rep_op),   32'(k % 2));
      check("coll_rep_data", 32'(rep_data), (k % 2 == 0) ? 32'(p_a) : 32'(p_d));
    end
    tick();
    #1;
    check("coll_drain", 32'(rep_vld), 32'h0);

    // ---- reply stall on requester 1 ----
    rep_rdy        = 4'b1101;
    rep_alloc_vld  = 1'b1;
    rep_alloc_data = {2'd1, p_r1};
    #1;
    check("stall_first_rdy", 32'(rep_alloc_rdy), 32'h1);
    tick();
    rep_alloc_data   = {2'd2, p_r2};
    rep_dealloc_vld  = 1'b1;
    rep_dealloc_data = {2'd3, p_r3};
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_rep_vld",     32'(rep_vld),         32'h2);
      check("stall_alloc_rdy",   32'(rep_alloc_rdy),   32'h0);
      check("stall_dealloc_rdy", 32'(rep_dealloc_rdy), 32'h0);
      tick();
    end
    rep_rdy = 4'b1111;
    #1;
    check("stall_release_alloc_rdy",   32'(rep_alloc_rdy),   32'h1);
    check("stall_release_dealloc_rdy", 32'(rep_dealloc_rdy), 32'h0);
    check("stall_release_rep_vld",     32'(rep_vld),         32'h2);
    tick();
    rep_alloc_vld = 1'b0;
    #1;
    check("stall_next_vld",  32'(rep_vld),  32'h4);
    check("stall_next_op",   32'(rep_op),   32'h0);
    check("stall_next_data", 32'(rep_data), 32'(p_r2));
    check("stall_next_dealloc_rdy", 32'(rep_dealloc_rdy), 32'h1);
    tick();
    rep_dealloc_vld = 1'b0;
    #1;
    check("stall_last_vld",  32'(rep_vld),  32'h8);
    check("stall_last_op",   32'(rep_op),   32'h1);
    check("stall_last_data", 32'(rep_data), 32'(p_r3));
    tick();
    #1;
    check("stall_drain", 32'(rep_vld), 32'h0);

    // ---- reset during ISSUE (rr_ptr is 0) ----
    alloc_rdy   = 1'b0;
    dealloc_rdy = 1'b0;
    req_vld     = 4'b0100;
    req_op      = 4'b0000;
    req_data[2] = p_s;
    #1;
    check("rmi_grant", 32'(req_rdy), 32'h4);
    tick();
    req_vld = '0;
    #1;
    check("rmi_issue_vld", 32'(alloc_vld), 32'h1);
    rst = 1'b1;
    tick();
    #1;
    check("rmi_alloc_vld",   32'(alloc_vld),   32'h0);
    check("rmi_dealloc_vld", 32'(dealloc_vld), 32'h0);
    check("rmi_req_rdy",     32'(req_rdy),     32'h0);
    check("rmi_rep_vld",     32'(rep_vld),     32'h0);
    rst       = 1'b0;
    alloc_rdy = 1'b1;
    req_vld   = 4'b1111;
    #1;
    check("rmi_rr_ptr_zero", 32'(req_rdy), 32'h1);
    req_vld = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      check("rmi_never_issued", 32'(alloc_vld),  32'h0);
      check("rmi_hold_cleared", 32'(alloc_data), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
